// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the UART receiver: FSM state encoding,
//               legal oversampling ratios and a prescale legality helper.
//               The PARITY state only exists when UART_RX_PARITY_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } rx_state_e;

   localparam logic [5:0] c_prescale_8  = 6'd8;
   localparam logic [5:0] c_prescale_16 = 6'd16;
   localparam logic [5:0] c_prescale_32 = 6'd32;

   function automatic logic prescale_legal(input logic [5:0] p);
      return (p == c_prescale_8) || (p == c_prescale_16) || (p == c_prescale_32);
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sampler
// Description : Per-bit edge counter, per-state bit index counter and 2-of-3
//               majority-vote sampler for the UART receiver.
// Ports       : clk, rst_n      - clock, asynchronous active-low reset
//               i_rx           - serial line
//               i_prescale     - latched oversampling ratio
//               i_load         - frame start: current edge is count 0
//               i_run          - a bit period is being timed
//               i_bit_clr      - clear the bit index (FSM state change)
//               o_bit_end      - current edge is the last edge of a bit
//               o_bit_val      - majority-voted value of the current bit
//               o_bit_idx      - index of the current bit within its state
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sampler #(
   parameter int DATA_WIDTH = 8,
   parameter int IDX_W      = $clog2(DATA_WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_rx,
   input  logic [5:0]       i_prescale,
   input  logic             i_load,
   input  logic             i_run,
   input  logic             i_bit_clr,
   output logic             o_bit_end,
   output logic             o_bit_val,
   output logic [IDX_W-1:0] o_bit_idx
);

   logic [5:0]       edge_cnt_q, edge_cnt_d;
   logic [2:0]       vote_q, vote_d;
   logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
   logic [5:0]       w_half;
   logic             w_last;
   logic             w_sample;

   assign w_half   = {1'b0, i_prescale[5:1]};
   // With an illegal prescale of 0 the wrap value is 63, which the 6-bit
   // counter still reaches, so a frame always terminates.
   assign w_last   = (edge_cnt_q == (i_prescale - 6'd1));
   assign w_sample = (edge_cnt_q == (w_half - 6'd1)) ||
                     (edge_cnt_q == w_half) ||
                     (edge_cnt_q == (w_half + 6'd1));

   always_comb begin
      edge_cnt_d = edge_cnt_q;
      vote_d     = vote_q;
      bit_idx_d  = bit_idx_q;

      // The edge that detected the falling start edge is count 0, so the
      // first timed edge of the start bit is count 1.
      if (i_load) begin
         edge_cnt_d = 6'd1;
      end else if (!i_run || w_last) begin
         edge_cnt_d = '0;
      end else begin
         edge_cnt_d = edge_cnt_q + 6'd1;
      end

      if (i_run && w_sample) begin
         vote_d = {vote_q[1:0], i_rx};
      end

      if (i_bit_clr) begin
         bit_idx_d = '0;
      end else if (i_run && w_last) begin
         bit_idx_d = bit_idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_cnt_q <= '0;
         vote_q     <= '0;
         bit_idx_q  <= '0;
      end else begin
         edge_cnt_q <= edge_cnt_d;
         vote_q     <= vote_d;
         bit_idx_q  <= bit_idx_d;
      end
   end

   assign o_bit_end = i_run && w_last;
   assign o_bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & vote_q[2]) |
                      (vote_q[1] & vote_q[2]);
   assign o_bit_idx = bit_idx_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : Oversampling UART receiver. FSM, data shifter, parity and
//               stop checks; bit timing and voting live in uart_rx_sampler.
//               Optional parity support: define UART_RX_PARITY_EN.
//               RX_IN is expected to be synchronous to CLK.
// Ports       : CLK        - oversampling clock (PRESCALE x bit rate)
//               RST        - asynchronous active-low reset
//               RX_IN      - serial line, idle high
//               PRESCALE   - oversampling ratio (8, 16, 32)
//               PAR_EN     - frame carries a parity bit
//               PAR_TYP    - 0 even, 1 odd parity
//               P_DATA     - received data, updated with Data_Valid
//               Data_Valid - one-cycle pulse, good frame received
//               Par_Err    - one-cycle pulse, parity mismatch
//               Stp_Err    - one-cycle pulse, stop bit sampled low
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic [5:0]            PRESCALE,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  Data_Valid,
   output logic                  Par_Err,
   output logic                  Stp_Err
);
   import uart_pkg::*;

   localparam int IDX_W = $clog2(DATA_WIDTH + 1);

   rx_state_e             state_q, state_d;
   logic [5:0]            prescale_q, prescale_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
   logic                  data_valid_q, data_valid_d;
   logic                  stp_err_q, stp_err_d;
   logic                  stop_done_q, stop_done_d;
   logic                  w_load, w_run, w_bit_clr;
   logic                  w_bit_end, w_bit_val, w_frame_ok;
   logic [IDX_W-1:0]      w_bit_idx;

`ifdef UART_RX_PARITY_EN
   logic par_en_q, par_en_d;
   logic par_typ_q, par_typ_d;
   logic par_err_q, par_err_d;
   logic par_bad_q, par_bad_d;
   assign w_frame_ok = !par_bad_q;
`else
   logic unused_par_cfg;
   assign unused_par_cfg = PAR_EN ^ PAR_TYP;
   assign w_frame_ok     = 1'b1;
`endif

   // STOP with stop_done_q set is the one-cycle look-ahead after the stop
   // bit; no bit is being timed there.
   assign w_run     = (state_q != ST_IDLE) && !stop_done_q;
   assign w_bit_clr = (state_d != state_q);

   uart_rx_sampler #(
      .DATA_WIDTH (DATA_WIDTH),
      .IDX_W      (IDX_W)
   ) u_sampler (
      .clk        (CLK),
      .rst_n      (RST),
      .i_rx       (RX_IN),
      .i_prescale (prescale_q),
      .i_load     (w_load),
      .i_run      (w_run),
      .i_bit_clr  (w_bit_clr),
      .o_bit_end  (w_bit_end),
      .o_bit_val  (w_bit_val),
      .o_bit_idx  (w_bit_idx)
   );

   always_comb begin
      state_d      = state_q;
      prescale_d   = prescale_q;
      shift_d      = shift_q;
      p_data_d     = p_data_q;
      data_valid_d = 1'b0;
      stp_err_d    = 1'b0;
      stop_done_d  = stop_done_q;
      w_load       = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_en_d     = par_en_q;
      par_typ_d    = par_typ_q;
      par_err_d    = 1'b0;
      par_bad_d    = par_bad_q;
`endif

      // A start bit is seen either from IDLE or right after a stop bit.
      if ((state_q == ST_IDLE || (state_q == ST_STOP && stop_done_q)) && !RX_IN) begin
         state_d     = ST_START;
         w_load      = 1'b1;
         stop_done_d = 1'b0;
         // Illegal ratios fall back to 16 so the receiver can never stall.
         prescale_d  = prescale_legal(PRESCALE) ? PRESCALE : c_prescale_16;
`ifdef UART_RX_PARITY_EN
         par_en_d    = PAR_EN;
         par_typ_d   = PAR_TYP;
         par_bad_d   = 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: ;
            ST_START: begin
               if (w_bit_end) begin
                  state_d = w_bit_val ? ST_IDLE : ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_bit_end) begin
                  shift_d = {w_bit_val, shift_q[DATA_WIDTH-1:1]};
                  if (w_bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
                     state_d = par_en_q ? ST_PARITY : ST_STOP;
`else
                     state_d = ST_STOP;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (w_bit_end) begin
                  state_d = ST_STOP;
                  if (w_bit_val != ((^shift_q) ^ par_typ_q)) begin
                     par_err_d = 1'b1;
                     par_bad_d = 1'b1;
                  end
               end
            end
`endif
            ST_STOP: begin
               if (stop_done_q) begin
                  state_d     = ST_IDLE;
                  stop_done_d = 1'b0;
               end else if (w_bit_end) begin
                  stop_done_d = 1'b1;
                  if (!w_bit_val) begin
                     stp_err_d = 1'b1;
                  end else if (w_frame_ok) begin
                     data_valid_d = 1'b1;
                     p_data_d     = shift_q;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q      <= ST_IDLE;
         prescale_q   <= c_prescale_16;
         shift_q      <= '0;
         p_data_q     <= '0;
         data_valid_q <= 1'b0;
         stp_err_q    <= 1'b0;
         stop_done_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_en_q     <= 1'b0;
         par_typ_q    <= 1'b0;
         par_err_q    <= 1'b0;
         par_bad_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         prescale_q   <= prescale_d;
         shift_q      <= shift_d;
         p_data_q     <= p_data_d;
         data_valid_q <= data_valid_d;
         stp_err_q    <= stp_err_d;
         stop_done_q  <= stop_done_d;
`ifdef UART_RX_PARITY_EN
         par_en_q     <= par_en_d;
         par_typ_q    <= par_typ_d;
         par_err_q    <= par_err_d;
         par_bad_q    <= par_bad_d;
`endif
      end
   end

   assign P_DATA     = p_data_q;
   assign Data_Valid = data_valid_q;
   assign Stp_Err    = stp_err_q;
`ifdef UART_RX_PARITY_EN
   assign Par_Err    = par_err_q;
`else
   assign Par_Err    = 1'b0;
`endif

endmodule
`default_nettype wire
